// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: turns LOAD / COUNT_UP n / COUNT_DOWN n / CLEAR commands
// into per-bit j/k drive for an external bank of JK flip-flops, reading the
// bank's q outputs back between steps so the bank behaves as a loadable
// up/down counter.
// Optional feature macro: JKSEQ_ABORT_EN adds an abort input and an aborted
// flag that truncates a multi-step command after the step in flight.
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             bank_clr,
  output logic             bank_prst,
  output logic             busy,
  output logic             done
`ifdef JKSEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CLR,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] steps;
  logic             count_up;
  logic             up_sel;
  logic [WIDTH-1:0] step_mask;
  logic             abort_now;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
  function automatic logic [WIDTH-1:0] toggle_mask(input logic [WIDTH-1:0] q,
                                                   input logic up);
    logic [WIDTH-1:0] m;
    logic             acc;
    acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = acc;
      acc  = acc & (up ? q[i] : ~q[i]);
    end
    return m;
  endfunction

  // In IDLE the direction comes straight from the incoming command; later from the captured op.
  assign up_sel    = (state == S_IDLE) ? (cmd_op == OP_UP) : count_up;
  assign step_mask = toggle_mask(q_in, up_sel);
  assign cmd_ready = (state == S_IDLE);

`ifdef JKSEQ_ABORT_EN
  logic abort_pending;

  assign abort_now = abort_pending | abort;

  // Remember an abort seen during DRIVE so SETTLE can end the command after this step.
  always_ff @(posedge clk) begin
    if (clr) begin
      abort_pending <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      case (state)
        S_DRIVE:  abort_pending <= abort_pending | abort;
        S_SETTLE: begin
          if (steps == '0 || abort_now) begin
            aborted       <= abort_now;
            abort_pending <= 1'b0;
          end
        end
        S_DONE:   aborted <= 1'b0;
        default:  abort_pending <= 1'b0;
      endcase
    end
  end
`else
  assign abort_now = 1'b0;
`endif

  // Main sequencer: state, step counter and all registered bank drive outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      steps     <= '0;
      count_up  <= 1'b0;
      j_out     <= '0;
      k_out     <= '0;
      bank_clr  <= 1'b0;
      bank_prst <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      j_out     <= '0;
      k_out     <= '0;
      bank_clr  <= 1'b0;
      bank_prst <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            busy     <= 1'b1;
            count_up <= (cmd_op == OP_UP);
            case (cmd_op)
              OP_LOAD: begin
                j_out <= cmd_data;
                k_out <= ~cmd_data;
                steps <= WIDTH'(1);
                state <= S_DRIVE;
              end
              OP_UP, OP_DOWN: begin
                if (cmd_data == '0) begin
                  done  <= 1'b1;
                  state <= S_DONE;
                end else begin
                  j_out <= step_mask;
                  k_out <= step_mask;
                  steps <= cmd_data;
                  state <= S_DRIVE;
                end
              end
              OP_CLEAR: begin
                bank_clr <= 1'b1;
                state    <= S_CLR;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_DRIVE: begin
          steps <= steps - WIDTH'(1);
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (steps != '0 && !abort_now) begin
            j_out <= step_mask;
            k_out <= step_mask;
            state <= S_DRIVE;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_CLR: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Testbench for jk_bank_sequencer: models the JK flip-flop bank, drives
// table-driven and random commands, and checks outputs against arithmetic
// expectations (bank value = init +/- steps mod 16, latency rules).
module tb_jk_bank_sequencer;
  localparam int W = 4;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic         clk = 1'b0;
  logic         clr;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] bank;
  logic [W-1:0] j_out, k_out;
  logic         bank_clr, bank_prst, busy, done;
  logic         preload;
  logic [W-1:0] preload_val;
`ifdef JKSEQ_ABORT_EN
  logic         abort;
  logic         aborted;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  jk_bank_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .q_in(bank),
    .j_out(j_out), .k_out(k_out), .bank_clr(bank_clr), .bank_prst(bank_prst),
    .busy(busy), .done(done)
`ifdef JKSEQ_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  // Flip-flop bank: clr beats prst, otherwise Q+ = J&~Q | ~K&Q per bit.
  always @(posedge clk) begin
    if (preload)        bank <= preload_val;
    else if (bank_clr)  bank <= '0;
    else if (bank_prst) bank <= '1;
    else                bank <= (j_out & ~bank) | (~k_out & bank);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_final(input logic [1:0] op, input logic [W-1:0] d,
                                             input logic [W-1:0] init);
    case (op)
      OP_LOAD: return d;
      OP_UP:   return W'(init + d);
      OP_DOWN: return W'(init - d);
      default: return '0;
    endcase
  endfunction

  task automatic set_bank(input logic [W-1:0] v);
    preload = 1'b1;
    preload_val = v;
    tick();
    preload = 1'b0;
  endtask

  // Issue one command and check every cycle until the controller is back in IDLE.
  task automatic run_cmd(input string nm, input logic [1:0] op, input logic [W-1:0] d,
                         input logic [W-1:0] init, input logic [W-1:0] exp_final);
    int lat;
    bit is_cnt;
    logic [W-1:0] b, nb, ej, ek;
    for (int t = 0; t < 50 && !cmd_ready; t++) tick();
    chk({nm, "/ready"}, cmd_ready, 1);
    set_bank(init);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
    is_cnt = (op == OP_UP || op == OP_DOWN);
    if (op == OP_LOAD) lat = 3;
    else if (op == OP_CLEAR) lat = 2;
    else lat = (d == 0) ? 1 : 2 * int'(d) + 1;
    for (int c = 1; c <= lat; c++) begin
      ej = '0; ek = '0;
      if (op == OP_LOAD && c == 1) begin ej = d; ek = ~d; end
      if (is_cnt && (c % 2 == 1) && c < lat) begin
        b  = (op == OP_UP) ? W'(init + (c - 1) / 2) : W'(init - (c - 1) / 2);
        nb = (op == OP_UP) ? W'(b + 1) : W'(b - 1);
        ej = b ^ nb; ek = b ^ nb;
      end
      chk({nm, "/j"}, j_out, ej);
      chk({nm, "/k"}, k_out, ek);
      chk({nm, "/bank_clr"}, bank_clr, (op == OP_CLEAR && c == 1) ? 1 : 0);
      chk({nm, "/bank_prst"}, bank_prst, 0);
      chk({nm, "/busy"}, busy, 1);
      chk({nm, "/cmd_ready"}, cmd_ready, 0);
      chk({nm, "/done"}, done, (c == lat) ? 1 : 0);
      if (is_cnt && (c % 2 == 0))
        chk({nm, "/step_bank"}, bank,
            (op == OP_UP) ? W'(init + c / 2) : W'(init - c / 2));
`ifdef JKSEQ_ABORT_EN
      if (c == lat) chk({nm, "/aborted"}, aborted, 0);
`endif
      if (c < lat) tick();
    end
    tick();
    chk({nm, "/idle_busy"}, busy, 0);
    chk({nm, "/idle_done"}, done, 0);
    chk({nm, "/idle_ready"}, cmd_ready, 1);
    chk({nm, "/final_bank"}, bank, exp_final);
    $display("cmd %s op=%0d data=%0d init=%0d -> bank=%0d (expect %0d)",
             nm, op, d, init, bank, exp_final);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    logic [W-1:0] init;
    logic [W-1:0] exp_final;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{OP_LOAD,  4'b1010, 4'b0101, 4'b1010};
    vecs[1] = '{OP_UP,    4'd3,    4'b1110, 4'b0001};
    vecs[2] = '{OP_DOWN,  4'd2,    4'b0001, 4'b1111};
    vecs[3] = '{OP_UP,    4'd0,    4'b0110, 4'b0110};
    vecs[4] = '{OP_CLEAR, 4'd9,    4'b1011, 4'b0000};
    vecs[5] = '{OP_UP,    4'd15,   4'b0000, 4'b1111};
    vecs[6] = '{OP_DOWN,  4'd1,    4'b0000, 4'b1111};
    vecs[7] = '{OP_DOWN,  4'd0,    4'b1001, 4'b1001};

    clr = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    preload = 1'b0; preload_val = '0;
`ifdef JKSEQ_ABORT_EN
    abort = 1'b0;
`endif
    // Reset held for two cycles.
    tick(); tick();
    chk("rst/j", j_out, 0);
    chk("rst/k", k_out, 0);
    chk("rst/bank_clr", bank_clr, 0);
    chk("rst/bank_prst", bank_prst, 0);
    chk("rst/done", done, 0);
    chk("rst/busy", busy, 0);
`ifdef JKSEQ_ABORT_EN
    chk("rst/aborted", aborted, 0);
`endif
    clr = 1'b0;
    tick();
    chk("rst/ready_after", cmd_ready, 1);
    $display("reset released, cmd_ready=%0d", cmd_ready);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].init,
              vecs[i].exp_final);

    // cmd_valid held high across a CLEAR: second accept only once back in IDLE.
    set_bank(4'b1011);
    cmd_valid = 1'b1; cmd_op = OP_CLEAR; cmd_data = '0;
    tick();
    chk("hold/c1_ready", cmd_ready, 0);
    chk("hold/c1_clr", bank_clr, 1);
    tick();
    chk("hold/c2_clr", bank_clr, 0);
    chk("hold/c2_done", done, 1);
    chk("hold/c2_bank", bank, 0);
    tick();
    chk("hold/c3_ready", cmd_ready, 1);
    chk("hold/c3_clr", bank_clr, 0);
    chk("hold/c3_done", done, 0);
    tick();
    cmd_valid = 1'b0;
    chk("hold/c4_clr", bank_clr, 1);
    tick(); tick();
    chk("hold/end_ready", cmd_ready, 1);
    $display("held-valid CLEAR sequence done");

    // Reset asserted during SETTLE of step 2 of COUNT_UP 5.
    set_bank(4'b0000);
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 4'd5;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    chk("midrst/settle_bank", bank, 2);
    clr = 1'b1;
    tick();
    chk("midrst/busy", busy, 0);
    chk("midrst/done", done, 0);
    chk("midrst/j", j_out, 0);
    chk("midrst/k", k_out, 0);
    chk("midrst/ready", cmd_ready, 1);
    clr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrst/no_done", done, 0);
      chk("midrst/bank_hold", bank, 2);
    end
    $display("mid-operation reset, bank=%0d", bank);

`ifdef JKSEQ_ABORT_EN
    // Abort during DRIVE of step 2 of COUNT_UP 5.
    set_bank(4'b0000);
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 4'd5;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("abort/bank1", bank, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort/bank2", bank, 2);
    chk("abort/no_done_yet", done, 0);
    tick();
    chk("abort/done", done, 1);
    chk("abort/aborted", aborted, 1);
    chk("abort/bank_final", bank, 2);
    tick();
    chk("abort/idle_busy", busy, 0);
    chk("abort/aborted_clr", aborted, 0);
    $display("abort sequence, bank=%0d", bank);
`endif

    // Random commands against the arithmetic reference.
    for (int r = 0; r < 40; r++) begin
      logic [1:0]   op;
      logic [W-1:0] d, init;
      op   = 2'($urandom_range(0, 3));
      d    = W'($urandom_range(0, 15));
      init = W'($urandom_range(0, 15));
      run_cmd($sformatf("rnd%0d", r), op, d, init, ref_final(op, d, init));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Controller that sequences an external bank of WIDTH JK flip-flops: clk, per-bit j/k, shared clr and prst, clr having priority over prst.
- Accepts commands over a valid/ready handshake: LOAD, COUNT UP n, COUNT DOWN n, CLEAR.
- Translates each command into per-bit j/k patterns. Reads the bank's q outputs back to compute the next step.
- Lets the bank act as a loadable up/down counter without per-bit glue logic.

Parameters:
WIDTH, 4, number of JK flip-flops in the bank; also the width of cmd_data.

Ports:
clk  input  1  system clock; all state changes on rising edge
clr  input  1  synchronous, active-high reset of this controller
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  2  00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 CLEAR
cmd_data  input  WIDTH  LOAD: value to load; COUNT_*: number of steps n; CLEAR: ignored
q_in  input  WIDTH  q outputs of the flip-flop bank, bit i = flop i
j_out  output  WIDTH  j inputs to the bank (registered)
k_out  output  WIDTH  k inputs to the bank (registered)
bank_clr  output  1  clr to every flop in the bank (registered)
bank_prst  output  1  prst to every flop in the bank (registered; held 0, reserved)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset: clk is the single clock. clr is synchronous and active-high. While clr=1 at a rising edge:
  - state goes to IDLE;
  - j_out=0, k_out=0, bank_clr=0, bank_prst=0, done=0, busy=0, step counter=0.
  - cmd_ready=1 from the first cycle after reset.
  - The bank contents are not touched by reset.
- Reset mid-operation abandons the command at once. No done pulse. The bank keeps whatever value it had reached.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_op and cmd_data are captured at that edge. Inputs are ignored while cmd_ready=0.
- States: IDLE, DRIVE, SETTLE, CLR, DONE.
- IDLE: j_out=k_out=0, so the bank holds. On accept:
  - LOAD: register j_out=cmd_data, k_out=~cmd_data; go to DRIVE with steps=1.
  - COUNT_*: if n=0, go to DONE directly (no drive). Otherwise register the first step's j/k from q_in and go to DRIVE with steps=n.
  - CLEAR: register bank_clr=1; go to CLR.
- DRIVE (1 cycle): j/k are stable; the bank samples them at the end of this cycle. Go to SETTLE; at that edge, j_out=k_out=0 and steps decrements.
- SETTLE (1 cycle): q_in now reflects the updated bank.
  - steps>0: register the next j/k from q_in; go to DRIVE.
  - steps=0: go to DONE.
- CLR (1 cycle): bank_clr=1 for exactly this cycle; go to DONE.
- DONE (1 cycle): done=1, busy=1; go to IDLE.
- Step patterns:
  - COUNT_UP: j[i]=k[i]=1 iff q_in[i-1:0] all ones (bit 0 always toggles).
  - COUNT_DOWN: j[i]=k[i]=1 iff q_in[i-1:0] all zeros.
- Wrap-around is modulo 2^WIDTH: up from all-ones gives 0; down from 0 gives all-ones.
- Latency:
  - COUNT n≥1 spends 2n cycles in DRIVE/SETTLE; done asserts in cycle 2n+1 after the accept edge.
  - LOAD: done in cycle 3. CLEAR: done in cycle 2. COUNT n=0: done in cycle 1.
- n is WIDTH bits wide, so at most 2^WIDTH-1 steps per command.
- bank_prst is driven 0 in every state.

Optional Feature:
Macro JKSEQ_ABORT_EN.
- Defined:
  - Extra input abort (1 bit) and extra output aborted (1 bit, valid with done).
  - abort=1 sampled in DRIVE or SETTLE lets the in-flight step finish. SETTLE then goes to DONE regardless of steps remaining, and aborted=1 alongside done.
  - abort in IDLE, CLR or DONE has no effect.
  - aborted resets to 0 and is 0 on normal completion.
- Not defined: neither port exists; every command runs to completion.

Test Plan:
- WIDTH=4, reset with clr=1 for 2 cycles -> all outputs 0, cmd_ready=1 on the cycle after clr falls.
- LOAD 4'b1010 with bench bank model at 4'b0101 -> DRIVE shows j=1010, k=0101; bank=1010 after DRIVE; done in cycle 3.
- Bank 4'b1110, COUNT_UP n=3 -> bank sequence 1111, 0000, 0001; done 7 cycles after accept; j=k=0 outside DRIVE.
- Bank 4'b0001, COUNT_DOWN n=2 -> 0000 then 1111 (wrap); COUNT_UP n=0 -> done 1 cycle after accept, j/k never asserted.
- CLEAR with bank 4'b1011 -> bank_clr high exactly 1 cycle, bank 0000, done next cycle; cmd_valid held high while busy -> no second accept until IDLE.
- Assert clr during SETTLE of COUNT_UP n=5 -> IDLE next cycle, no done, bank holds its partial count. With JKSEQ_ABORT_EN: abort in step 2 of n=5 -> done with aborted=1 after step 2 completes.
